// File: rtl/calc_pkg.sv
// Shared types and defaults for the calculator input conditioning slice.
`timescale 1ns/1ps
package calc_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int SW_W                = 16;

endpackage

// File: rtl/calc_input_cond_btn_debounce.sv
// One raw button: synchroniser, debounce FSM with saturating stability
// counter, debounced level and one-cycle rise strobe.
`timescale 1ns/1ps
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // The sample that enters WAIT_* counts as the first stable one,
  // so the commit fires when the increment would reach DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (s) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!s) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level = 1'b0;
    rise  = rise_q;
    unique case (state_q)
      STABLE_HI, WAIT_LO: level = 1'b1;
      default:            level = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_input_cond.sv
// Board input conditioning: debounced buttons, btnd press strobe,
// synchronised switch word. btnu is the asynchronous reset.
`timescale 1ns/1ps
module calc_input_cond
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            btnu,
  input  logic            btnc,
  input  logic            btnl,
  input  logic            btnr,
  input  logic            btnd,
  input  logic [SW_W-1:0] sw,
  output logic            btnc_db,
  output logic            btnl_db,
  output logic            btnr_db,
  output logic            btnd_pulse,
  output logic [SW_W-1:0] sw_sync
);

  logic rst;
  assign rst = btnu;

  logic unused_c_rise;
  logic unused_l_rise;
  logic unused_r_rise;
  logic unused_d_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btnc (
    .clk  (clk),
    .rst  (rst),
    .raw  (btnc),
    .level(btnc_db),
    .rise (unused_c_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btnl (
    .clk  (clk),
    .rst  (rst),
    .raw  (btnl),
    .level(btnl_db),
    .rise (unused_l_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btnr (
    .clk  (clk),
    .rst  (rst),
    .raw  (btnr),
    .level(btnr_db),
    .rise (unused_r_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_btnd (
    .clk  (clk),
    .rst  (rst),
    .raw  (btnd),
    .level(unused_d_level),
    .rise (btnd_pulse)
  );

  // Switches are level inputs with no bounce concern; sync only.
  logic [SW_W-1:0] sw_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_q[i] <= '0;
    end else begin
      sw_q[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_q[i] <= sw_q[i-1];
    end
  end

  assign sw_sync = sw_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_calc_input_cond.sv
// Directed and randomised checks of calc_input_cond against a
// sample-history model, DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
`timescale 1ns/1ps
module tb_calc_input_cond;

  localparam int DC = 4;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        btnu = 1'b1;
  logic        btnc = 1'b0;
  logic        btnl = 1'b0;
  logic        btnr = 1'b0;
  logic        btnd = 1'b0;
  logic [15:0] sw = 16'h0;
  logic        btnc_db, btnl_db, btnr_db, btnd_pulse;
  logic [15:0] sw_sync;

  int n_tests = 0;
  int n_fail  = 0;

  calc_input_cond #(
    .DEBOUNCE_CYCLES(DC),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk       (clk),
    .btnu      (btnu),
    .btnc      (btnc),
    .btnl      (btnl),
    .btnr      (btnr),
    .btnd      (btnd),
    .sw        (sw),
    .btnc_db   (btnc_db),
    .btnl_db   (btnl_db),
    .btnr_db   (btnr_db),
    .btnd_pulse(btnd_pulse),
    .sw_sync   (sw_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // Model: each button's FSM view is its raw sample from SS edges ago;
  // a run of DC consecutive views differing from the level flips it.
  logic [3:0]  bq[$];
  logic [15:0] sq[$];
  logic [3:0]  m_lvl;
  int          m_run[4];
  logic        m_pulse;
  logic [15:0] m_sw;

  task automatic model_clear();
    bq.delete();
    sq.delete();
    for (int i = 0; i < SS; i++) begin
      bq.push_back(4'h0);
      sq.push_back(16'h0);
    end
    m_lvl   = 4'h0;
    m_pulse = 1'b0;
    m_sw    = 16'h0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    s = bq[SS-1];
    bq.push_front({btnd, btnr, btnl, btnc});
    void'(bq.pop_back());
    m_pulse = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (s[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DC) begin
          m_lvl[b] = ~m_lvl[b];
          m_run[b] = 0;
          if (b == 3 && m_lvl[b]) m_pulse = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    sq.push_front(sw);
    void'(sq.pop_back());
    m_sw = sq[SS-1];
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge btnu);
      if (btnu) model_clear();
      else model_edge();
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    forever begin
      @(negedge clk);
      chk("m_btnc_db", 16'(btnc_db), 16'(m_lvl[0]));
      chk("m_btnl_db", 16'(btnl_db), 16'(m_lvl[1]));
      chk("m_btnr_db", 16'(btnr_db), 16'(m_lvl[2]));
      chk("m_btnd_pulse", 16'(btnd_pulse), 16'(m_pulse));
      chk("m_sw_sync", sw_sync, m_sw);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk(name, {btnc_db, btnl_db, btnr_db, btnd_pulse}, 16'h0);
    chk(name, sw_sync, 16'h0);
  endtask

  logic pat [8];

  initial begin
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    repeat (3) tick();
    btnu = 1'b0;
    tick();

    // 1: async reset between edges
    btnc = 1'b1;
    sw   = 16'h00FF;
    repeat (8) tick();
    chk("t1_pre_btnc_db", 16'(btnc_db), 16'h1);
    chk("t1_pre_sw", sw_sync, 16'h00FF);
    #3;
    btnu = 1'b1;
    #1;
    chk_zero("t1_async_clear");
    btnc = 1'b0;
    sw   = 16'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_zero("t1_hold");
    end
    btnu = 1'b0;
    repeat (4) tick();

    // 2: btnd press held 20 cycles, then release
    btnd = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 20) btnd = 1'b0;
      chk("t2_pulse", 16'(btnd_pulse), 16'(k == 6));
    end

    // 3: bouncing btnc; last 0->1 sample is edge 4, commit at edge 9
    for (int k = 1; k <= 14; k++) begin
      btnc = (k <= 8) ? pat[k-1] : 1'b1;
      tick();
      chk("t3_btnc_db", 16'(btnc_db), 16'(k >= 9));
    end
    btnc = 1'b0;
    repeat (8) tick();

    // 4: 1- and 2-cycle glitches on btnr
    for (int k = 1; k <= 16; k++) begin
      btnr = (k == 1) || (k == 7) || (k == 8);
      tick();
      chk("t4_btnr_db", 16'(btnr_db), 16'h0);
    end
    btnr = 1'b0;
    repeat (4) tick();

    // 5: switch sync and simultaneous btnl/btnr press
    sw   = 16'h8001;
    btnl = 1'b1;
    btnr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_sw", sw_sync, (k >= 2) ? 16'h8001 : 16'h0000);
      chk("t5_btnl_db", 16'(btnl_db), 16'(k >= 6));
      chk("t5_btnr_db", 16'(btnr_db), 16'(k >= 6));
    end
    btnl = 1'b0;
    btnr = 1'b0;
    sw   = 16'h0;
    repeat (8) tick();

    // 6: reset mid-debounce of btnd
    btnd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_pre_pulse", 16'(btnd_pulse), 16'h0);
    end
    btnu = 1'b1;
    tick();
    chk("t6_rst_pulse", 16'(btnd_pulse), 16'h0);
    btnu = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_pulse", 16'(btnd_pulse), 16'(k == 6));
    end
    btnd = 1'b0;
    repeat (8) tick();

    // randomised: buttons held for random lengths, occasional reset
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(5) == 0) btnc = ~btnc;
      if ($urandom_range(5) == 0) btnl = ~btnl;
      if ($urandom_range(5) == 0) btnr = ~btnr;
      if ($urandom_range(5) == 0) btnd = ~btnd;
      if ($urandom_range(7) == 0) sw = 16'($urandom);
      btnu = ($urandom_range(299) == 0);
      tick();
    end
    btnu = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
